// File: rtl/bist_sequencer_if.sv
// Interface between the top-level test controller (master) and the BIST
// sequencer (slave). When BIST_ABORT_EN is defined the bundle also carries
// the bist_abort request from the controller.
interface bist_sequencer_if #(
  parameter int SIG_WIDTH = 16,
  parameter int CNT_W     = 7
);
  logic                 bist_start;
  logic [SIG_WIDTH-1:0] misr_sig;
`ifdef BIST_ABORT_EN
  logic                 bist_abort;
`endif
  logic                 bist_en;
  logic                 scan_en;
  logic                 TPG_reset;
  logic                 COMP_reset;
  logic                 comp_en;
  logic                 bist_busy;
  logic                 bist_done;
  logic                 bist_pass;
  logic [CNT_W-1:0]     pattern_cnt;

`ifdef BIST_ABORT_EN
  modport master (
    output bist_start, misr_sig, bist_abort,
    input  bist_en, scan_en, TPG_reset, COMP_reset, comp_en,
           bist_busy, bist_done, bist_pass, pattern_cnt
  );
  modport slave (
    input  bist_start, misr_sig, bist_abort,
    output bist_en, scan_en, TPG_reset, COMP_reset, comp_en,
           bist_busy, bist_done, bist_pass, pattern_cnt
  );
`else
  modport master (
    output bist_start, misr_sig,
    input  bist_en, scan_en, TPG_reset, COMP_reset, comp_en,
           bist_busy, bist_done, bist_pass, pattern_cnt
  );
  modport slave (
    input  bist_start, misr_sig,
    output bist_en, scan_en, TPG_reset, COMP_reset, comp_en,
           bist_busy, bist_done, bist_pass, pattern_cnt
  );
`endif
endinterface

// File: rtl/bist_sequencer.sv
// Logic BIST sequencer for the s9234 scan datapath. Runs NUM_PATTERNS
// load/capture/unload passes over the scan chains, then compares the MISR
// signature against GOLDEN_SIG. Optional feature macro: BIST_ABORT_EN adds
// an abort request that forces DONE with a failing result.
//
// state   | meaning
// IDLE    | TPG/MISR held in reset, waiting for bist_start
// INIT    | one cycle, TPG/MISR reset, counters cleared
// SHIFT   | CHAIN_LEN shift cycles; first pass loads only, later passes also unload into MISR
// CAPTURE | one functional capture cycle, pattern count advances
// COMPARE | one cycle, signature compared against golden value
// DONE    | result held; waits for bist_start to drop
module bist_sequencer #(
  parameter int                   CHAIN_LEN    = 33,
  parameter int                   NUM_PATTERNS = 100,
  parameter int                   SIG_WIDTH    = 16,
  parameter logic [SIG_WIDTH-1:0] GOLDEN_SIG   = '0
) (
  input  logic            CK,
  input  logic            BIST_reset,
  bist_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(NUM_PATTERNS + 1);
  localparam int SH_W  = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INIT    = 3'd1;
  localparam logic [2:0] S_SHIFT   = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_COMPARE = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]      state;
  logic [2:0]      state_nxt;
  logic [SH_W-1:0] shift_cnt;
  logic [SH_W-1:0] shift_nxt;
  logic [CNT_W-1:0] pat_cnt;
  logic [CNT_W-1:0] pat_nxt;
  logic            abort;
  logic            running;
  logic            last_shift;
  logic            last_pat;
  logic            sig_match;

`ifdef BIST_ABORT_EN
  assign abort = bus.bist_abort;
`else
  assign abort = 1'b0;
`endif

  assign running    = (state == S_INIT) || (state == S_SHIFT) ||
                      (state == S_CAPTURE) || (state == S_COMPARE);
  assign last_shift = (shift_cnt == SH_W'(CHAIN_LEN - 1));
  assign last_pat   = (pat_cnt == CNT_W'(NUM_PATTERNS));
  assign sig_match  = (bus.misr_sig == GOLDEN_SIG);

  // Next-state decode; abort overrides every transition while a run is active.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (bus.bist_start) state_nxt = S_INIT;
      S_INIT:    state_nxt = S_SHIFT;
      S_SHIFT:   if (last_shift) state_nxt = last_pat ? S_COMPARE : S_CAPTURE;
      S_CAPTURE: state_nxt = S_SHIFT;
      S_COMPARE: state_nxt = S_DONE;
      S_DONE:    if (!bus.bist_start) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
    if (abort && running) state_nxt = S_DONE;
  end

  // Counter next values: shift count wraps each pass, pattern count saturates.
  always_comb begin
    shift_nxt = shift_cnt;
    pat_nxt   = pat_cnt;
    if (state == S_INIT) begin
      shift_nxt = '0;
      pat_nxt   = '0;
    end else if (state == S_SHIFT) begin
      shift_nxt = last_shift ? '0 : shift_cnt + SH_W'(1);
    end else if (state == S_CAPTURE && !abort && !last_pat) begin
      pat_nxt = pat_cnt + CNT_W'(1);
    end
  end

  // State, counters and Moore outputs registered from the next state.
  always_ff @(posedge CK) begin
    if (BIST_reset) begin
      state          <= S_IDLE;
      shift_cnt      <= '0;
      pat_cnt        <= '0;
      bus.bist_en    <= 1'b0;
      bus.scan_en    <= 1'b0;
      bus.TPG_reset  <= 1'b1;
      bus.COMP_reset <= 1'b1;
      bus.comp_en    <= 1'b0;
      bus.bist_busy  <= 1'b0;
      bus.bist_done  <= 1'b0;
      bus.bist_pass  <= 1'b0;
    end else begin
      state          <= state_nxt;
      shift_cnt      <= shift_nxt;
      pat_cnt        <= pat_nxt;
      bus.bist_en    <= (state_nxt == S_INIT) || (state_nxt == S_SHIFT) ||
                        (state_nxt == S_CAPTURE) || (state_nxt == S_COMPARE);
      bus.bist_busy  <= (state_nxt == S_INIT) || (state_nxt == S_SHIFT) ||
                        (state_nxt == S_CAPTURE) || (state_nxt == S_COMPARE);
      bus.scan_en    <= (state_nxt == S_SHIFT);
      bus.TPG_reset  <= (state_nxt == S_IDLE) || (state_nxt == S_INIT);
      bus.COMP_reset <= (state_nxt == S_IDLE) || (state_nxt == S_INIT);
      // The first pass only loads the chains; unload data is compacted from pass two on.
      bus.comp_en    <= (state_nxt == S_SHIFT) && (pat_nxt != '0);
      bus.bist_done  <= (state_nxt == S_DONE);
      if (state_nxt != S_DONE)
        bus.bist_pass <= 1'b0;
      else if (state == S_COMPARE && !abort)
        bus.bist_pass <= sig_match;
      else if (state != S_DONE)
        bus.bist_pass <= 1'b0;
    end
  end

  assign bus.pattern_cnt = pat_cnt;

endmodule

// File: tb/tb_bist_sequencer.sv
// Scoreboard bench for bist_sequencer with CHAIN_LEN=4, NUM_PATTERNS=3.
// Stimulus pushes the expected completion (cycle, pass, count); a negedge
// monitor pops and compares on every rising bist_done.
module tb_bist_sequencer;
  localparam int CL    = 4;
  localparam int NP    = 3;
  localparam int SW    = 16;
  localparam int CNT_W = $clog2(NP + 1);
  localparam logic [SW-1:0] GOLD = 16'hA5C3;
  localparam int LAT_FULL = 21;

  typedef struct {
    int   cyc;
    logic pass;
    int   cnt;
    bit   chk_cnt;
  } exp_t;

  logic CK = 1'b0;
  logic BIST_reset = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic prev_done = 1'b0;
  exp_t sb[$];

  bist_sequencer_if #(.SIG_WIDTH(SW), .CNT_W(CNT_W)) bus();

  bist_sequencer #(
    .CHAIN_LEN(CL), .NUM_PATTERNS(NP), .SIG_WIDTH(SW), .GOLDEN_SIG(GOLD)
  ) dut (
    .CK(CK), .BIST_reset(BIST_reset), .bus(bus)
  );

  always #5 CK = ~CK;
  always @(posedge CK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic push_exp(input int lat, input logic pass, input int cnt, input bit chk_cnt);
    exp_t e;
    e.cyc = cyc + 1 + lat;
    e.pass = pass;
    e.cnt = cnt;
    e.chk_cnt = chk_cnt;
    sb.push_back(e);
  endtask

  task automatic wait_done();
    int n = 0;
    while (bus.bist_done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("done_seen", bus.bist_done, 1);
  endtask

  // Monitor: compare each completed run against the oldest expectation.
  always @(negedge CK) begin
    exp_t e;
    if (bus.bist_done === 1'b1 && prev_done !== 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("done_cycle", cyc, e.cyc);
        check("pass", bus.bist_pass, e.pass);
        if (e.chk_cnt) check("pattern_cnt", bus.pattern_cnt, e.cnt);
      end
    end
    prev_done = bus.bist_done;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [18:0] scan_act, comp_act, scan_exp, comp_exp;
    int k;
    bus.bist_start = 1'b0;
    bus.misr_sig   = GOLD;
`ifdef BIST_ABORT_EN
    bus.bist_abort = 1'b0;
`endif
    repeat (3) tick();
    check("rst_tpg", bus.TPG_reset, 1);
    check("rst_comp", bus.COMP_reset, 1);
    check("rst_outs", {bus.bist_en, bus.scan_en, bus.comp_en, bus.bist_busy,
                       bus.bist_done, bus.bist_pass}, 0);
    check("rst_cnt", bus.pattern_cnt, 0);
    BIST_reset = 1'b0;
    tick();

    // T1 + T3: passing run with waveform capture
    k = 0;
    for (int p = 0; p <= NP; p++) begin
      for (int s = 0; s < CL; s++) begin
        scan_exp[18-k] = 1'b1;
        comp_exp[18-k] = (p > 0);
        k++;
      end
      if (p < NP) begin
        scan_exp[18-k] = 1'b0;
        comp_exp[18-k] = 1'b0;
        k++;
      end
    end
    push_exp(LAT_FULL, 1'b1, NP, 1'b1);
    bus.bist_start = 1'b1;
    tick();
    bus.bist_start = 1'b0;
    check("init_tpg", bus.TPG_reset, 1);
    check("init_busy", bus.bist_busy, 1);
    for (int i = 0; i < 19; i++) begin
      tick();
      scan_act[18-i] = bus.scan_en;
      comp_act[18-i] = bus.comp_en;
    end
    check("scan_wave", scan_act, scan_exp);
    check("comp_wave", comp_act, comp_exp);
    wait_done();
    check("done_bist_en", bus.bist_en, 0);
    check("done_resets", {bus.TPG_reset, bus.COMP_reset}, 0);
    tick();
    check("idle_tpg", bus.TPG_reset, 1);
    check("idle_done", {bus.bist_done, bus.bist_pass}, 0);

    // T2: signature mismatch
    bus.misr_sig = GOLD ^ 16'h0001;
    push_exp(LAT_FULL, 1'b0, NP, 1'b1);
    bus.bist_start = 1'b1;
    tick();
    bus.bist_start = 1'b0;
    wait_done();
    tick();
    bus.misr_sig = GOLD;

    // T4: reset in the second shift pass
    bus.bist_start = 1'b1;
    tick();
    bus.bist_start = 1'b0;
    repeat (7) tick();
    check("t4_in_shift", bus.scan_en, 1);
    BIST_reset = 1'b1;
    tick();
    check("t4_resets", {bus.TPG_reset, bus.COMP_reset}, 2'b11);
    check("t4_busy_done", {bus.bist_busy, bus.bist_done}, 0);
    check("t4_cnt", bus.pattern_cnt, 0);
    BIST_reset = 1'b0;
    repeat (30) tick();
    check("t4_stays_idle", bus.bist_busy, 0);

    // T5: start held through DONE
    push_exp(LAT_FULL, 1'b1, NP, 1'b1);
    bus.bist_start = 1'b1;
    tick();
    wait_done();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_hold_done", {bus.bist_done, bus.bist_busy}, 2'b10);
    end
    bus.bist_start = 1'b0;
    tick();
    check("t5_idle", {bus.bist_done, bus.bist_busy, bus.TPG_reset}, 3'b001);
    push_exp(LAT_FULL, 1'b1, NP, 1'b1);
    bus.bist_start = 1'b1;
    tick();
    bus.bist_start = 1'b0;
    wait_done();
    tick();

`ifdef BIST_ABORT_EN
    // T6: abort during the second capture
    push_exp(11, 1'b0, 0, 1'b0);
    bus.bist_start = 1'b1;
    tick();
    bus.bist_start = 1'b0;
    repeat (10) tick();
    check("t6_in_capture", {bus.bist_busy, bus.scan_en}, 2'b10);
    bus.bist_abort = 1'b1;
    tick();
    bus.bist_abort = 1'b0;
    check("t6_done", bus.bist_done, 1);
    tick();
`endif

    repeat (3) tick();
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
